// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm ring controller:
//   - state_e : FSM state encoding (IDLE / RING / SNOOZE)
//   - default values for the controller timing parameters
// -----------------------------------------------------------------------------
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_e;

  localparam int SNOOZE_SEC_DEF       = 300;
  localparam int RING_TIMEOUT_SEC_DEF = 60;
  localparam int MAX_SNOOZE_DEF       = 3;
  localparam int BEEP_HALF_CYCLES_DEF = 25_000_000;

endpackage : alarm_pkg

// File: rtl/beep_gen.sv
// -----------------------------------------------------------------------------
// beep_gen
// Square-wave phase generator for the buzzer.
//   clk, reset : clock, asynchronous active-low reset
//   enable     : count and toggle the phase every BEEP_HALF_CYCLES cycles
//   restart    : force phase = 1 and clear the counter (wins over enable)
//   phase      : registered beep phase; held low while neither input is set,
//                so it can drive the buzzer directly
// -----------------------------------------------------------------------------
module beep_gen
  import alarm_pkg::*;
#(
  parameter int BEEP_HALF_CYCLES = BEEP_HALF_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic phase
);

  localparam int BW = (BEEP_HALF_CYCLES > 1) ? $clog2(BEEP_HALF_CYCLES) : 1;
  localparam logic [BW-1:0] CNT_LAST = BW'(BEEP_HALF_CYCLES - 1);

  logic [BW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (enable) begin
      // The counter spans one half-period; at its last value it returns to
      // zero and the phase flips.
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule : beep_gen

// File: rtl/alarm_ring_controller.sv
// -----------------------------------------------------------------------------
// alarm_ring_controller
// Sequences an alarm event: RING (beeping) -> optional SNOOZE -> re-RING,
// until stopped, disabled or (optionally) timed out.
//
// Optional feature macro: ALARM_RING_TIMEOUT_EN
//   defined   : ring timer present, RING auto-exits after RING_TIMEOUT_SEC
//               ticks; `missed` port and RING_TIMEOUT_SEC parameter exist
//   undefined : RING lasts until stop, snooze or disable
//
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   tick_1s           : one-cycle pulse per second
//   alarm_enabled     : level, low forces IDLE
//   alarm_triggered   : one-cycle pulse, starts RING from IDLE
//   btn_stop          : one-cycle pulse, ends the event
//   btn_snooze        : one-cycle pulse, RING -> SNOOZE (limited count)
//   buzzer            : beep drive (registered)
//   ringing, snoozing : state is RING / SNOOZE (registered)
//   stop_alarm        : one-cycle pulse on every exit to IDLE (not on reset)
//   state_dbg         : current FSM state for observation
//   snooze_count      : snoozes used in this event
//   missed            : sticky, alarm timed out unattended (macro only)
//
// Handshake: all inputs are sampled on the rising clk edge; every output
// reflects the decision of that edge one cycle later. There is no
// backpressure -- pulses arriving when they have no meaning are dropped.
// -----------------------------------------------------------------------------
module alarm_ring_controller
  import alarm_pkg::*;
#(
  parameter int SNOOZE_SEC       = SNOOZE_SEC_DEF,
`ifdef ALARM_RING_TIMEOUT_EN
  parameter int RING_TIMEOUT_SEC = RING_TIMEOUT_SEC_DEF,
`endif
  parameter int MAX_SNOOZE       = MAX_SNOOZE_DEF,
  parameter int BEEP_HALF_CYCLES = BEEP_HALF_CYCLES_DEF,
  localparam int SCW             = $clog2(MAX_SNOOZE + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick_1s,
  input  logic           alarm_enabled,
  input  logic           alarm_triggered,
  input  logic           btn_stop,
  input  logic           btn_snooze,
  output logic           buzzer,
  output logic           ringing,
  output logic           snoozing,
  output logic           stop_alarm,
  output logic [1:0]     state_dbg,
  output logic [SCW-1:0] snooze_count
`ifdef ALARM_RING_TIMEOUT_EN
  ,
  output logic           missed
`endif
);

  localparam int STW = $clog2(SNOOZE_SEC + 1);
  localparam logic [SCW-1:0] SNOOZE_MAX  = SCW'(MAX_SNOOZE);
  localparam logic [STW-1:0] SNOOZE_LOAD = STW'(SNOOZE_SEC);
  localparam logic [STW-1:0] SNOOZE_ONE  = STW'(1);

  state_e         state_q, state_d;
  logic [SCW-1:0] snooze_cnt_q, snooze_cnt_d;
  logic [STW-1:0] snooze_tmr_q, snooze_tmr_d;
  logic           ringing_q, ringing_d;
  logic           snoozing_q, snoozing_d;
  logic           stop_q, stop_d;
  logic           beep_enable, beep_restart, beep_phase;

`ifdef ALARM_RING_TIMEOUT_EN
  localparam int RTW = $clog2(RING_TIMEOUT_SEC + 1);
  localparam logic [RTW-1:0] RING_LAST = RTW'(RING_TIMEOUT_SEC - 1);

  logic [RTW-1:0] ring_tmr_q, ring_tmr_d;
  logic           missed_q, missed_d;
`endif

  always_comb begin
    state_d      = state_q;
    snooze_cnt_d = snooze_cnt_q;
    snooze_tmr_d = snooze_tmr_q;
    stop_d       = 1'b0;
`ifdef ALARM_RING_TIMEOUT_EN
    ring_tmr_d   = ring_tmr_q;
    missed_d     = missed_q;
    // Acknowledging the missed flag with stop while idle.
    if (state_q == ST_IDLE && btn_stop) begin
      missed_d = 1'b0;
    end
`endif

    if (!alarm_enabled) begin
      state_d = ST_IDLE;
      stop_d  = (state_q != ST_IDLE);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (alarm_triggered) begin
            state_d      = ST_RING;
            snooze_cnt_d = '0;
`ifdef ALARM_RING_TIMEOUT_EN
            ring_tmr_d   = '0;
            missed_d     = 1'b0;
`endif
          end
        end
        ST_RING: begin
          if (btn_stop) begin
            state_d = ST_IDLE;
            stop_d  = 1'b1;
          end else if (btn_snooze && (snooze_cnt_q < SNOOZE_MAX)) begin
            state_d      = ST_SNOOZE;
            snooze_cnt_d = snooze_cnt_q + 1'b1;
            snooze_tmr_d = SNOOZE_LOAD;
          end
`ifdef ALARM_RING_TIMEOUT_EN
          // An exhausted snooze press falls through here, so the ring timer
          // keeps running.
          else if (tick_1s) begin
            if (ring_tmr_q == RING_LAST) begin
              state_d  = ST_IDLE;
              stop_d   = 1'b1;
              missed_d = 1'b1;
            end else begin
              ring_tmr_d = ring_tmr_q + 1'b1;
            end
          end
`endif
        end
        ST_SNOOZE: begin
          if (btn_stop) begin
            state_d = ST_IDLE;
            stop_d  = 1'b1;
          end else if (tick_1s) begin
            // The tick that takes the timer to zero re-rings immediately.
            if (snooze_tmr_q <= SNOOZE_ONE) begin
              snooze_tmr_d = '0;
              state_d      = ST_RING;
`ifdef ALARM_RING_TIMEOUT_EN
              ring_tmr_d   = '0;
`endif
            end else begin
              snooze_tmr_d = snooze_tmr_q - 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    ringing_d    = (state_d == ST_RING);
    snoozing_d   = (state_d == ST_SNOOZE);
    // Restart on every entry into RING, count while staying in RING; any
    // other case forces the phase (and thus the buzzer) low.
    beep_restart = (state_d == ST_RING) && (state_q != ST_RING);
    beep_enable  = (state_d == ST_RING) && (state_q == ST_RING);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      snooze_cnt_q <= '0;
      snooze_tmr_q <= '0;
      ringing_q    <= 1'b0;
      snoozing_q   <= 1'b0;
      stop_q       <= 1'b0;
`ifdef ALARM_RING_TIMEOUT_EN
      ring_tmr_q   <= '0;
      missed_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      snooze_cnt_q <= snooze_cnt_d;
      snooze_tmr_q <= snooze_tmr_d;
      ringing_q    <= ringing_d;
      snoozing_q   <= snoozing_d;
      stop_q       <= stop_d;
`ifdef ALARM_RING_TIMEOUT_EN
      ring_tmr_q   <= ring_tmr_d;
      missed_q     <= missed_d;
`endif
    end
  end

  beep_gen #(
    .BEEP_HALF_CYCLES(BEEP_HALF_CYCLES)
  ) u_beep_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (beep_enable),
    .restart(beep_restart),
    .phase  (beep_phase)
  );

  assign buzzer       = beep_phase;
  assign ringing      = ringing_q;
  assign snoozing     = snoozing_q;
  assign stop_alarm   = stop_q;
  assign state_dbg    = state_q;
  assign snooze_count = snooze_cnt_q;
`ifdef ALARM_RING_TIMEOUT_EN
  assign missed       = missed_q;
`endif

endmodule : alarm_ring_controller

// File: tb/tb_alarm_ring_controller.sv
// -----------------------------------------------------------------------------
// tb_alarm_ring_controller
// Directed bench for alarm_ring_controller with SNOOZE_SEC=3,
// RING_TIMEOUT_SEC=5 (macro builds), MAX_SNOOZE=2, BEEP_HALF_CYCLES=4 and a
// tick_1s pulse every 20 cycles. A behavioural model predicts the full
// output word for each cycle into exp_q; the word is popped and compared
// after the clock edge. Directed checks pin the timing points of each step.
// -----------------------------------------------------------------------------
module tb_alarm_ring_controller;

  localparam int SNZ  = 3;
  localparam int TO   = 5;
  localparam int MAXS = 2;
  localparam int HALF = 4;
  localparam int SCW  = 2;
  localparam int W    = 2 + 5 + SCW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           tick_1s, alarm_enabled, alarm_triggered, btn_stop, btn_snooze;
  logic           buzzer, ringing, snoozing, stop_alarm;
  logic [1:0]     state_dbg;
  logic [SCW-1:0] snooze_count;
  logic           missed_v;
`ifdef ALARM_RING_TIMEOUT_EN
  logic           missed;
  assign missed_v = missed;
`else
  assign missed_v = 1'b0;
`endif

  alarm_ring_controller #(
    .SNOOZE_SEC      (SNZ),
`ifdef ALARM_RING_TIMEOUT_EN
    .RING_TIMEOUT_SEC(TO),
`endif
    .MAX_SNOOZE      (MAXS),
    .BEEP_HALF_CYCLES(HALF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .tick_1s        (tick_1s),
    .alarm_enabled  (alarm_enabled),
    .alarm_triggered(alarm_triggered),
    .btn_stop       (btn_stop),
    .btn_snooze     (btn_snooze),
    .buzzer         (buzzer),
    .ringing        (ringing),
    .snoozing       (snoozing),
    .stop_alarm     (stop_alarm),
    .state_dbg      (state_dbg),
    .snooze_count   (snooze_count)
`ifdef ALARM_RING_TIMEOUT_EN
    ,
    .missed         (missed)
`endif
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  int   tick_cnt = 0;
  logic last_tick = 1'b0;

  // model state
  int   m_st, m_cnt, m_snz, m_ring, m_bcnt;
  logic m_phase, m_missed, m_stop;

  function automatic logic [W-1:0] dut_vec();
    return {state_dbg, ringing, snoozing, buzzer, stop_alarm, missed_v, snooze_count};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_snz = 0; m_ring = 0; m_bcnt = 0;
    m_phase = 1'b0; m_missed = 1'b0; m_stop = 1'b0;
  endtask

  // Predict the outputs produced by the next rising edge from current inputs.
  task automatic model_step();
    int           pst;
    logic         restart;
    logic [1:0]   s2;
    logic [SCW-1:0] c2;
    logic         mv;
    pst     = m_st;
    restart = 1'b0;
    m_stop  = 1'b0;
    if (pst == 0 && btn_stop) m_missed = 1'b0;
    if (!alarm_enabled) begin
      if (pst != 0) m_stop = 1'b1;
      m_st = 0;
    end else begin
      case (pst)
        0: if (alarm_triggered) begin
             m_st = 1; m_cnt = 0; m_ring = 0; m_missed = 1'b0; restart = 1'b1;
           end
        1: begin
             if (btn_stop) begin
               m_st = 0; m_stop = 1'b1;
             end else if (btn_snooze && m_cnt < MAXS) begin
               m_st = 2; m_cnt = m_cnt + 1; m_snz = SNZ;
             end
`ifdef ALARM_RING_TIMEOUT_EN
             else if (tick_1s) begin
               m_ring = m_ring + 1;
               if (m_ring == TO) begin
                 m_st = 0; m_stop = 1'b1; m_missed = 1'b1;
               end
             end
`endif
           end
        default: begin
             if (btn_stop) begin
               m_st = 0; m_stop = 1'b1;
             end else if (tick_1s) begin
               m_snz = m_snz - 1;
               if (m_snz == 0) begin
                 m_st = 1; m_ring = 0; restart = 1'b1;
               end
             end
           end
      endcase
    end
    if (restart) begin
      m_phase = 1'b1; m_bcnt = 0;
    end else if (pst == 1 && m_st == 1) begin
      m_bcnt = m_bcnt + 1;
      if (m_bcnt == HALF) begin
        m_bcnt = 0; m_phase = ~m_phase;
      end
    end else begin
      m_phase = 1'b0; m_bcnt = 0;
    end
    s2 = m_st[1:0];
    c2 = m_cnt[SCW-1:0];
`ifdef ALARM_RING_TIMEOUT_EN
    mv = m_missed;
`else
    mv = 1'b0;
`endif
    exp_q.push_back({s2, (m_st == 1), (m_st == 2), m_phase, m_stop, mv, c2});
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge with pulses already set; advances one cycle,
  // compares the predicted word, then clears the one-cycle pulses.
  task automatic step();
    logic [W-1:0] exp;
    tick_1s   = (tick_cnt == 19);
    last_tick = tick_1s;
    tick_cnt  = (tick_cnt == 19) ? 0 : tick_cnt + 1;
    model_step();
    @(posedge clk);
    @(negedge clk);
    exp = exp_q.pop_front();
    check("cycle_word", dut_vec(), exp);
    alarm_triggered = 1'b0;
    btn_stop        = 1'b0;
    btn_snooze      = 1'b0;
    tick_1s         = 1'b0;
  endtask

  // Step until ringing equals want (bounded); returns ticks seen meanwhile.
  task automatic run_until_ringing(input logic want, output int ticks);
    ticks = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (last_tick) ticks++;
      if (ringing === want) return;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int ticks;
    reset           = 1'b0;
    tick_1s         = 1'b0;
    alarm_enabled   = 1'b0;
    alarm_triggered = 1'b0;
    btn_stop        = 1'b0;
    btn_snooze      = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_word", dut_vec(), '0);
    reset         = 1'b1;
    alarm_enabled = 1'b1;
    repeat (3) step();

    // Ring, beep pattern, stop
    alarm_triggered = 1'b1;
    step();
    check("t1_ringing", ringing, 1'b1);
    check("t1_buzzer", buzzer, 1'b1);
    for (int i = 2; i <= 9; i++) begin
      step();
      check("t1_beep", buzzer, (((i - 1) / 4) % 2) == 0);
    end
    step();
    btn_stop = 1'b1;
    step();
    check("t1_stop_pulse", stop_alarm, 1'b1);
    check("t1_stop_ringing", ringing, 1'b0);
    step();
    check("t1_stop_low", stop_alarm, 1'b0);
    check("t1_idle", state_dbg, 2'd0);

    // Snooze, re-ring, snooze limit
    alarm_triggered = 1'b1;
    step();
    btn_snooze = 1'b1;
    step();
    check("t2_snoozing", snoozing, 1'b1);
    check("t2_ring_off", ringing, 1'b0);
    check("t2_buzz_off", buzzer, 1'b0);
    check("t2_count1", snooze_count, 2'd1);
    run_until_ringing(1'b1, ticks);
    check("t2_rering", ringing, 1'b1);
    check("t2_ticks", ticks, 3);
    btn_snooze = 1'b1;
    step();
    check("t2_count2", snooze_count, 2'd2);
    run_until_ringing(1'b1, ticks);
    check("t2_rering2", ringing, 1'b1);
    btn_snooze = 1'b1;
    step();
    check("t2_ignored_ring", ringing, 1'b1);
    check("t2_ignored_cnt", snooze_count, 2'd2);
    step();
    btn_stop   = 1'b1;
    btn_snooze = 1'b1;
    step();
    check("t3_stop_pulse", stop_alarm, 1'b1);
    check("t3_idle", state_dbg, 2'd0);
    check("t3_cnt_kept", snooze_count, 2'd2);
    step();

    // Disable during snooze, trigger while disabled
    alarm_triggered = 1'b1;
    step();
    check("t5_cnt_clear", snooze_count, 2'd0);
    btn_snooze = 1'b1;
    step();
    repeat (5) step();
    alarm_enabled = 1'b0;
    step();
    check("t5_dis_snooze", snoozing, 1'b0);
    check("t5_dis_stop", stop_alarm, 1'b1);
    step();
    check("t5_dis_stop_low", stop_alarm, 1'b0);
    alarm_triggered = 1'b1;
    step();
    check("t5_trig_ignored", ringing, 1'b0);
    alarm_enabled = 1'b1;
    step();

`ifdef ALARM_RING_TIMEOUT_EN
    // Unattended timeout
    alarm_triggered = 1'b1;
    step();
    run_until_ringing(1'b0, ticks);
    check("t4_to_stop", stop_alarm, 1'b1);
    check("t4_missed", missed, 1'b1);
    check("t4_ticks", ticks, TO);
    step();
    alarm_triggered = 1'b1;
    step();
    check("t4_missed_clr", missed, 1'b0);
    btn_stop = 1'b1;
    step();
    step();
`endif

    // Asynchronous reset mid-beep
    alarm_triggered = 1'b1;
    step();
    step();
    step();
    check("t6_pre_buzz", buzzer, 1'b1);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("t6_async_word", dut_vec(), '0);
    @(posedge clk);
    @(negedge clk);
    check("t6_no_stop", stop_alarm, 1'b0);
    reset = 1'b1;
    step();
    check("t6_idle_after", dut_vec(), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_alarm_ring_controller
